// File: rtl/alu_rs_if.sv
// Bundle of the reservation-station ports: dispatch, result-bus snoop, ALU request/response and broadcast.
// Latency: wires only, no storage.
// Backpressure: full flows toward the dispatcher; the other directions carry no stall.
interface alu_rs_if #(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 2
);
   // dispatch port
   logic                 in_valid;
   logic [3:0]           in_op;
   logic [31:0]          in_vj;
   logic                 in_qj_valid;
   logic [ROB_WIDTH-1:0] in_qj;
   logic [31:0]          in_vk;
   logic                 in_qk_valid;
   logic [ROB_WIDTH-1:0] in_qk;
   logic [ROB_WIDTH-1:0] in_dest;
   logic                 full;
   // external result bus snoop
   logic                 cdb_valid;
   logic [ROB_WIDTH-1:0] cdb_tag;
   logic [31:0]          cdb_value;
   // ALU request
   logic                 alu_cal;
   logic [31:0]          alu_a;
   logic [31:0]          alu_b;
   logic [3:0]           alu_op;
   logic [RS_WIDTH-1:0]  alu_rs_index;
   // ALU response
   logic                 alu_done;
   logic [RS_WIDTH-1:0]  alu_done_index;
   logic [31:0]          alu_result;
   // result broadcast
   logic                 out_valid;
   logic [ROB_WIDTH-1:0] out_tag;
   logic [31:0]          out_value;

   modport master (
      output in_valid, in_op, in_vj, in_qj_valid, in_qj, in_vk, in_qk_valid, in_qk, in_dest,
      output cdb_valid, cdb_tag, cdb_value,
      output alu_done, alu_done_index, alu_result,
      input  full, alu_cal, alu_a, alu_b, alu_op, alu_rs_index,
      input  out_valid, out_tag, out_value
   );

   modport slave (
      input  in_valid, in_op, in_vj, in_qj_valid, in_qj, in_vk, in_qk_valid, in_qk, in_dest,
      input  cdb_valid, cdb_tag, cdb_value,
      input  alu_done, alu_done_index, alu_result,
      output full, alu_cal, alu_a, alu_b, alu_op, alu_rs_index,
      output out_valid, out_tag, out_value
   );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: parks ops until both operands are known, issues the lowest ready entry.
// Latency: issue no earlier than the cycle after dispatch; broadcast is combinational with alu_done.
// Backpressure: full blocks dispatch; rdy_in=0 freezes dispatch/issue/flush while completion drains.
module alu_rs #(
   parameter int ROB_WIDTH = 4,
   parameter int RS_WIDTH  = 2
) (
   input  logic    clk_in,
   input  logic    rst_in,
   input  logic    rdy_in,
   input  logic    clear,
   alu_rs_if.slave bus
);
   localparam int N = 2 ** RS_WIDTH;

   typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_ISSUED} ent_state_t;

   ent_state_t           state   [N];
   ent_state_t           state_d [N];
   logic [3:0]           op_q    [N];
   logic [31:0]          vj_q    [N];
   logic [31:0]          vk_q    [N];
   logic                 qj_vld_q[N];
   logic                 qk_vld_q[N];
   logic [ROB_WIDTH-1:0] qj_q    [N];
   logic [ROB_WIDTH-1:0] qk_q    [N];
   logic [ROB_WIDTH-1:0] dest_q  [N];

   logic                free_any;
   logic [RS_WIDTH-1:0] free_idx;
   logic                ready_any;
   logic [RS_WIDTH-1:0] ready_idx;
   logic                flush;
   logic                dispatch;
   logic                issue;
   logic                complete;

   // {hit, value} per waiting operand and for the incoming dispatch operands
   logic [32:0] wake_j [N];
   logic [32:0] wake_k [N];
   logic [32:0] disp_j;
   logic [32:0] disp_k;

   // The external bus wins when both sources carry the same tag.
   function automatic logic [32:0] snoop(
      input logic [ROB_WIDTH-1:0] tag,
      input logic                 c_vld,
      input logic [ROB_WIDTH-1:0] c_tag,
      input logic [31:0]          c_val,
      input logic                 o_vld,
      input logic [ROB_WIDTH-1:0] o_tag,
      input logic [31:0]          o_val
   );
      logic [32:0] r;
      r = '0;
      if (o_vld && (o_tag == tag)) r = {1'b1, o_val};
      if (c_vld && (c_tag == tag)) r = {1'b1, c_val};
      return r;
   endfunction

   // Priority pick of the lowest free slot and the lowest ready slot, from cycle-start state.
   always_comb begin
      free_any  = 1'b0;
      free_idx  = '0;
      ready_any = 1'b0;
      ready_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (state[i] == ST_FREE) begin
            free_any = 1'b1;
            free_idx = RS_WIDTH'(i);
         end
         if ((state[i] == ST_WAIT) && !qj_vld_q[i] && !qk_vld_q[i]) begin
            ready_any = 1'b1;
            ready_idx = RS_WIDTH'(i);
         end
      end
   end

   assign flush    = rdy_in & clear;
   assign dispatch = rst_in & rdy_in & ~clear & bus.in_valid & free_any;
   assign issue    = rst_in & rdy_in & ~clear & ready_any;
   // a response for a slot that is no longer ISSUED (flushed) is dropped
   assign complete = rst_in & bus.alu_done & ~flush & (state[bus.alu_done_index] == ST_ISSUED);

   assign bus.full = rst_in & ~free_any;

   // ALU request: operands of the selected entry, all-zero when idle.
   always_comb begin
      bus.alu_cal      = 1'b0;
      bus.alu_a        = '0;
      bus.alu_b        = '0;
      bus.alu_op       = '0;
      bus.alu_rs_index = '0;
      if (issue) begin
         bus.alu_cal      = 1'b1;
         bus.alu_a        = vj_q[ready_idx];
         bus.alu_b        = vk_q[ready_idx];
         bus.alu_op       = op_q[ready_idx];
         bus.alu_rs_index = ready_idx;
      end
   end

   // Result broadcast straight from the ALU response, tagged with the entry's destination.
   always_comb begin
      bus.out_valid = 1'b0;
      bus.out_tag   = '0;
      bus.out_value = '0;
      if (complete) begin
         bus.out_valid = 1'b1;
         bus.out_tag   = dest_q[bus.alu_done_index];
         bus.out_value = bus.alu_result;
      end
   end

   // Tag match of every pending operand against both result sources.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         wake_j[i] = snoop(qj_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value,
                           bus.out_valid, bus.out_tag, bus.out_value);
         wake_k[i] = snoop(qk_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value,
                           bus.out_valid, bus.out_tag, bus.out_value);
      end
      disp_j = snoop(bus.in_qj, bus.cdb_valid, bus.cdb_tag, bus.cdb_value,
                     bus.out_valid, bus.out_tag, bus.out_value);
      disp_k = snoop(bus.in_qk, bus.cdb_valid, bus.cdb_tag, bus.cdb_value,
                     bus.out_valid, bus.out_tag, bus.out_value);
   end

   // Next entry state: flush dominates; otherwise complete, issue and allocate touch disjoint slots.
   always_comb begin
      for (int i = 0; i < N; i++) state_d[i] = state[i];
      if (flush) begin
         for (int i = 0; i < N; i++) state_d[i] = ST_FREE;
      end else begin
         if (complete) state_d[bus.alu_done_index] = ST_FREE;
         if (issue)    state_d[ready_idx]          = ST_ISSUED;
         if (dispatch) state_d[free_idx]           = ST_WAIT;
      end
   end

   // Entry state register, cleared asynchronously by reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N; i++) state[i] <= ST_FREE;
      end else begin
         for (int i = 0; i < N; i++) state[i] <= state_d[i];
      end
   end

   // Operand payload: load on allocate (with same-cycle capture), otherwise pick up wakeups.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < N; i++) begin
            op_q[i]     <= '0;
            vj_q[i]     <= '0;
            vk_q[i]     <= '0;
            qj_vld_q[i] <= 1'b0;
            qk_vld_q[i] <= 1'b0;
            qj_q[i]     <= '0;
            qk_q[i]     <= '0;
            dest_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (dispatch && (free_idx == RS_WIDTH'(i))) begin
               op_q[i]     <= bus.in_op;
               dest_q[i]   <= bus.in_dest;
               qj_q[i]     <= bus.in_qj;
               qk_q[i]     <= bus.in_qk;
               vj_q[i]     <= (bus.in_qj_valid && disp_j[32]) ? disp_j[31:0] : bus.in_vj;
               vk_q[i]     <= (bus.in_qk_valid && disp_k[32]) ? disp_k[31:0] : bus.in_vk;
               qj_vld_q[i] <= bus.in_qj_valid & ~disp_j[32];
               qk_vld_q[i] <= bus.in_qk_valid & ~disp_k[32];
            end else if (state[i] == ST_WAIT) begin
               if (qj_vld_q[i] && wake_j[i][32]) begin
                  vj_q[i]     <= wake_j[i][31:0];
                  qj_vld_q[i] <= 1'b0;
               end
               if (qk_vld_q[i] && wake_k[i][32]) begin
                  vk_q[i]     <= wake_k[i][31:0];
                  qk_vld_q[i] <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: reference model predicts requests/broadcasts, monitor retires them.
// Latency: expectations stamped with their cycle so late or early issue is caught.
// Backpressure: the bench plays a one-cycle ALU and exercises full, rdy_in and clear.
`timescale 1ns/1ps
module tb_alu_rs;
   localparam int RW = 4;
   localparam int SW = 2;
   localparam int N  = 4;
   localparam int M_FREE = 0;
   localparam int M_WAIT = 1;
   localparam int M_ISS  = 2;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear;

   always #5 clk_in = ~clk_in;

   alu_rs_if #(.ROB_WIDTH(RW), .RS_WIDTH(SW)) bus ();

   alu_rs #(.ROB_WIDTH(RW), .RS_WIDTH(SW)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .rdy_in (rdy_in),
      .clear  (clear),
      .bus    (bus)
   );

   typedef struct {
      int          st;
      logic [3:0]  op;
      logic [31:0] vj;
      logic [31:0] vk;
      logic        jw;
      logic        kw;
      logic [RW-1:0] qj;
      logic [RW-1:0] qk;
      logic [RW-1:0] dest;
   } ent_t;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      int          idx;
   } req_t;

   typedef struct {
      int            cyc;
      logic [RW-1:0] tag;
      logic [31:0]   val;
   } res_t;

   ent_t   m [N];
   req_t   req_q [$];
   res_t   res_q [$];
   logic   full_q [$];
   int     cyc;
   int     checks;
   int     fails;
   bit     mon_en;
   bit     pend_vld;
   int     pend_idx;
   logic [31:0] pend_res;
   bit     late_vld;
   int     late_idx;
   logic [31:0] late_res;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a ^ b;
         default: return a & b;
      endcase
   endfunction

   // Result-source lookup; the external bus has priority on a tag collision.
   function automatic bit lookup(input logic [RW-1:0] t, input bit ov, input logic [RW-1:0] otag,
                                 input logic [31:0] oval, output logic [31:0] v);
      v = '0;
      if (bus.cdb_valid && bus.cdb_tag == t) begin
         v = bus.cdb_value;
         return 1'b1;
      end
      if (ov && otag == t) begin
         v = oval;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] vj, input logic jw,
                        input logic [RW-1:0] qj, input logic [31:0] vk, input logic kw,
                        input logic [RW-1:0] qk, input logic [RW-1:0] dest);
      bus.in_valid = v;      bus.in_op = op;
      bus.in_vj = vj;        bus.in_qj_valid = jw;  bus.in_qj = qj;
      bus.in_vk = vk;        bus.in_qk_valid = kw;  bus.in_qk = qk;
      bus.in_dest = dest;
   endtask

   task automatic cdb(input logic v, input logic [RW-1:0] t, input logic [31:0] val);
      bus.cdb_valid = v; bus.cdb_tag = t; bus.cdb_value = val;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cdb(0, 0, 0);
   endtask

   // One cycle of the reference model, evaluated on the inputs currently driven.
   task automatic model_eval();
      ent_t nx [N];
      bit any_free, any_ready, ov, cal, flush, hit;
      int fidx, ridx, didx;
      logic [RW-1:0] otag;
      logic [31:0]   oval, v;
      req_t rq;
      res_t rs;
      flush = rdy_in && clear;
      any_free = 0; fidx = 0; any_ready = 0; ridx = 0;
      for (int i = 0; i < N; i++) begin
         if (m[i].st == M_FREE && !any_free) begin any_free = 1; fidx = i; end
         if (m[i].st == M_WAIT && !m[i].jw && !m[i].kw && !any_ready) begin any_ready = 1; ridx = i; end
      end
      full_q.push_back(!any_free);
      didx = int'(bus.alu_done_index);
      ov   = bus.alu_done && m[didx].st == M_ISS && !flush;
      otag = ov ? m[didx].dest : '0;
      oval = ov ? bus.alu_result : '0;
      if (ov) begin
         rs.cyc = cyc; rs.tag = otag; rs.val = oval;
         res_q.push_back(rs);
      end
      cal = any_ready && rdy_in && !clear;
      if (cal) begin
         rq.cyc = cyc; rq.a = m[ridx].vj; rq.b = m[ridx].vk; rq.op = m[ridx].op; rq.idx = ridx;
         req_q.push_back(rq);
      end
      pend_vld = cal;
      pend_idx = ridx;
      pend_res = alu_fn(m[ridx].op, m[ridx].vj, m[ridx].vk);
      nx = m;
      if (flush) begin
         for (int i = 0; i < N; i++) nx[i].st = M_FREE;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (m[i].st == M_WAIT) begin
               if (m[i].jw && lookup(m[i].qj, ov, otag, oval, v)) begin nx[i].vj = v; nx[i].jw = 0; end
               if (m[i].kw && lookup(m[i].qk, ov, otag, oval, v)) begin nx[i].vk = v; nx[i].kw = 0; end
            end
         end
         if (ov)  nx[didx].st = M_FREE;
         if (cal) nx[ridx].st = M_ISS;
         if (bus.in_valid && any_free && rdy_in) begin
            nx[fidx].st = M_WAIT;
            nx[fidx].op = bus.in_op;
            nx[fidx].dest = bus.in_dest;
            nx[fidx].qj = bus.in_qj;
            nx[fidx].qk = bus.in_qk;
            hit = bus.in_qj_valid && lookup(bus.in_qj, ov, otag, oval, v);
            nx[fidx].vj = hit ? v : bus.in_vj;
            nx[fidx].jw = bus.in_qj_valid && !hit;
            hit = bus.in_qk_valid && lookup(bus.in_qk, ov, otag, oval, v);
            nx[fidx].vk = hit ? v : bus.in_vk;
            nx[fidx].kw = bus.in_qk_valid && !hit;
         end
      end
      m = nx;
   endtask

   task automatic apply_done();
      bus.alu_done       = pend_vld | late_vld;
      bus.alu_done_index = late_vld ? SW'(late_idx) : SW'(pend_idx);
      bus.alu_result     = late_vld ? late_res : (pend_vld ? pend_res : 32'd0);
   endtask

   task automatic step();
      apply_done();
      model_eval();
      @(posedge clk_in);
      #1;
      late_vld = 0;
      cyc++;
   endtask

   // Scoreboard monitor: samples mid-cycle and retires expectations in order.
   always @(negedge clk_in) begin : mon
      logic e;
      req_t r;
      res_t o;
      if (rst_in && mon_en) begin
         if (full_q.size() > 0) begin
            e = full_q.pop_front();
            chk("full", 32'(bus.full), 32'(e));
         end
         if (bus.alu_cal) begin
            if (req_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_alu_cal: got index %0d expected no request (cycle %0d)", bus.alu_rs_index, cyc);
            end else begin
               r = req_q.pop_front();
               chk("issue_cycle", 32'(cyc), 32'(r.cyc));
               chk("alu_a", bus.alu_a, r.a);
               chk("alu_b", bus.alu_b, r.b);
               chk("alu_op", 32'(bus.alu_op), 32'(r.op));
               chk("alu_rs_index", 32'(bus.alu_rs_index), 32'(r.idx));
            end
         end else begin
            chk("alu_idle_zero", bus.alu_a | bus.alu_b | 32'(bus.alu_op) | 32'(bus.alu_rs_index), 32'd0);
         end
         if (bus.out_valid) begin
            if (res_q.size() == 0) begin
               checks++; fails++;
               $display("FAIL unexpected_out_valid: got tag %0d expected no broadcast (cycle %0d)", bus.out_tag, cyc);
            end else begin
               o = res_q.pop_front();
               chk("out_cycle", 32'(cyc), 32'(o.cyc));
               chk("out_tag", 32'(bus.out_tag), 32'(o.tag));
               chk("out_value", bus.out_value, o.val);
            end
         end else begin
            chk("out_idle_zero", 32'(bus.out_tag) | bus.out_value, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_in = 0; rdy_in = 1; clear = 0;
      idle();
      pend_vld = 0; pend_idx = 0; pend_res = '0;
      late_vld = 0; late_idx = 0; late_res = '0;
      cyc = 0; checks = 0; fails = 0; mon_en = 0;
      for (int i = 0; i < N; i++) m[i] = '{M_FREE, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, '0, '0, '0};
      apply_done();
      #2;
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_alu_cal", 32'(bus.alu_cal), 32'd0);
      chk("rst_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
      chk("rst_alu_op_idx", 32'(bus.alu_op) | 32'(bus.alu_rs_index), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_tag_value", 32'(bus.out_tag) | bus.out_value, 32'd0);
      #6;
      rst_in = 1;
      mon_en = 1;

      // add 5+7 to tag 3, ready on dispatch
      drive(1, 4'd0, 32'd5, 0, 0, 32'd7, 0, 0, 4'd3); step();
      idle(); repeat (3) step();

      // Vj waits on tag 6, woken by the bus two cycles later
      drive(1, 4'd0, 32'd0, 1, 4'd6, 32'd1, 0, 0, 4'd2); step();
      idle(); step();
      cdb(1, 4'd6, 32'd9); step();
      idle(); repeat (3) step();

      // fill all four slots with blocked ops, a fifth is dropped, then release slot 0
      for (int i = 0; i < N; i++) begin
         drive(1, 4'(i), $urandom, 1, 4'(8 + i), $urandom, 0, 0, 4'(i)); step();
      end
      drive(1, 4'd0, 32'd1, 0, 0, 32'd2, 0, 0, 4'd5); step();
      idle(); cdb(1, 4'd8, 32'd100); step();
      idle(); repeat (3) step();

      // flush leftovers, then flush with two ops in flight and a stray late response
      clear = 1; step(); clear = 0;
      drive(1, 4'd0, 32'd1, 0, 0, 32'd2, 0, 0, 4'd4); step();
      drive(1, 4'd1, 32'd10, 0, 0, 32'd3, 0, 0, 4'd5); step();
      idle(); clear = 1; step(); clear = 0;
      late_vld = 1; late_idx = 1; late_res = 32'd77; step();
      repeat (2) step();

      // slots 1 and 2 become ready on the same wakeup
      drive(1, 4'd0, 32'd1, 1, 4'd14, 32'd1, 0, 0, 4'd1); step();
      drive(1, 4'd0, 32'd2, 1, 4'd13, 32'd2, 0, 0, 4'd2); step();
      drive(1, 4'd2, 32'd3, 0, 0, 32'd3, 1, 4'd13, 4'd3); step();
      idle(); cdb(1, 4'd13, 32'd50); step();
      idle(); repeat (4) step();

      // rdy_in low: dispatch blocked, wakeup still lands
      rdy_in = 0;
      drive(1, 4'd1, 32'd9, 0, 0, 32'd4, 0, 0, 4'd6); step();
      idle(); cdb(1, 4'd14, 32'd20); step();
      idle(); step();
      rdy_in = 1; repeat (3) step();
      // completion drains while rdy_in is low
      drive(1, 4'd2, 32'hF0, 0, 0, 32'h0F, 0, 0, 4'd7); step();
      idle(); step();
      rdy_in = 0; step(); step();
      rdy_in = 1; step();

      // randomized traffic
      repeat (400) begin
         rdy_in = ($urandom_range(0, 7) != 0);
         clear  = ($urandom_range(0, 39) == 0);
         drive($urandom_range(0, 1), 4'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1),
               4'($urandom_range(0, 7)), $urandom, $urandom_range(0, 1), 4'($urandom_range(0, 7)),
               4'($urandom_range(0, 7)));
         cdb($urandom_range(0, 9) < 3, 4'($urandom_range(0, 7)), $urandom);
         step();
      end
      rdy_in = 1; clear = 1; idle(); step(); clear = 0;
      repeat (2) step();

      // reset asserted while an issue is on the ALU port
      drive(1, 4'd0, 32'd21, 0, 0, 32'd4, 0, 0, 4'd9); step();
      idle(); apply_done(); model_eval();
      @(negedge clk_in); #1;
      rst_in = 0; #1;
      chk("rst_mid_alu_cal", 32'(bus.alu_cal), 32'd0);
      chk("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_mid_full", 32'(bus.full), 32'd0);
      for (int i = 0; i < N; i++) m[i].st = M_FREE;
      pend_vld = 0;
      @(posedge clk_in); #1; cyc++;
      @(posedge clk_in); #3;
      rst_in = 1; cyc++;
      drive(1, 4'd1, 32'd30, 0, 0, 32'd8, 0, 0, 4'd10); step();
      idle(); repeat (4) step();

      checks++;
      if (req_q.size() != 0) begin
         fails++;
         $display("FAIL req_queue_drained: got %0d pending expected 0", req_q.size());
      end
      checks++;
      if (res_q.size() != 0) begin
         fails++;
         $display("FAIL res_queue_drained: got %0d pending expected 0", res_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
